// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store sequencer:
//   - RV32 load/store funct3 encodings
//   - lsu_state_e : sequencer FSM states
//   - lsu_err_e   : response error codes driven on rsp_err
//   - size_code() : access width code taken from funct3[1:0]
// -----------------------------------------------------------------------------
package lsu_pkg;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access width codes (funct3[1:0])
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    OK       = 2'd0,
    MISALIGN = 2'd1,
    BUSERR   = 2'd2,
    TIMEOUT  = 2'd3
  } lsu_err_e;

  // Loads and stores share the width encoding in the low two funct3 bits.
  function automatic logic [1:0] size_code(input logic [2:0] funct3);
    return funct3[1:0];
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// -----------------------------------------------------------------------------
// lsu_ctrl_if
// Bundles the command, response and data-memory bus signals of lsu_ctrl.
//   slave  : view of the sequencer itself (takes commands, drives mem bus)
//   master : view of the environment (CPU execute stage + memory)
// Signals:
//   req_*  : command from execute stage (valid/ready handshake)
//   rsp_*  : one-cycle response pulse with data, tag and error code
//   busy   : pipeline stall while an access is outstanding
//   mem_*  : single-port data-memory bus (req/gnt, rvalid/rdata/err)
// -----------------------------------------------------------------------------
interface lsu_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic [1:0]  rsp_err;
  logic        busy;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output rsp_valid, rsp_data, rsp_rd, rsp_err, busy,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_rd, rsp_err, busy,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err
  );

endinterface

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational byte-lane logic for one access.
// Ports:
//   we_i       : 1=store, 0=load (selects the legal funct3 set)
//   funct3_i   : RV32 load/store funct3
//   off_i      : byte offset addr[1:0]
//   wdata_i    : right-justified store data
//   rdata_i    : raw memory read word
//   be_o       : byte enables for the access width at this offset
//   wdata_o    : store data replicated into every lane of its width
//   rdata_o    : read data shifted down to bit 0 and sign/zero extended
//   legal_o    : funct3 is a valid encoding for this direction
//   aligned_o  : offset is naturally aligned for the access width
// -----------------------------------------------------------------------------
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        legal_o,
  output logic        aligned_o
);

  logic [31:0] shifted;
  logic [1:0]  size;

  assign size    = size_code(funct3_i);
  assign shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    if (we_i) begin
      legal_o = (funct3_i == F3_SB) || (funct3_i == F3_SH) || (funct3_i == F3_SW);
    end else begin
      legal_o = (funct3_i == F3_LB)  || (funct3_i == F3_LH)  || (funct3_i == F3_LW) ||
                (funct3_i == F3_LBU) || (funct3_i == F3_LHU);
    end
  end

  always_comb begin
    aligned_o = 1'b0;
    be_o      = 4'b0000;
    wdata_o   = wdata_i;
    case (size)
      SZ_BYTE: begin
        aligned_o = 1'b1;
        be_o      = 4'b0001 << off_i;
        wdata_o   = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        aligned_o = ~off_i[0];
        be_o      = 4'b0011 << off_i;
        wdata_o   = {2{wdata_i[15:0]}};
      end
      SZ_WORD: begin
        aligned_o = (off_i == 2'b00);
        be_o      = 4'b1111;
        wdata_o   = wdata_i;
      end
      default: begin
        aligned_o = 1'b0;
        be_o      = 4'b0000;
        wdata_o   = wdata_i;
      end
    endcase
  end

  always_comb begin
    rdata_o = 32'h0;
    case (funct3_i)
      F3_LB:   rdata_o = {{24{shifted[7]}},  shifted[7:0]};
      F3_LH:   rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   rdata_o = shifted;
      F3_LBU:  rdata_o = {24'h0, shifted[7:0]};
      F3_LHU:  rdata_o = {16'h0, shifted[15:0]};
      default: rdata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
// Load/store sequencer between the execute stage and the data-memory bus.
// Accepts one command at a time, checks legality/alignment, runs the
// req/gnt/rvalid handshake and returns exactly one response per command.
// Parameters:
//   TIMEOUT_CYC : cycles spent in REQ+WAIT before the access is aborted
//                 with a timeout response; 0 disables the timeout
//   CNT_W       : timeout counter width (TIMEOUT_CYC < 2**CNT_W)
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; abandons any access in flight
//   bus   : lsu_ctrl_if.slave (command, response and memory bus signals)
// -----------------------------------------------------------------------------
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e        state_q,  state_d;
  lsu_err_e          err_q,    err_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              we_q,     we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       addr_q,   addr_d;
  logic [31:0]       wdata_q,  wdata_d;
  logic [4:0]        rd_q,     rd_d;
  logic [31:0]       rsp_data_q, rsp_data_d;

  logic              in_idle;
  logic              in_req;
  logic              timeout_hit;

  // Lane logic inputs: the live command while idle (for the accept-time
  // legality check), the captured command for the rest of the access.
  logic              al_we;
  logic [2:0]        al_funct3;
  logic [1:0]        al_off;
  logic [31:0]       al_wdata;
  logic [3:0]        al_be;
  logic [31:0]       al_wlanes;
  logic [31:0]       al_rdata;
  logic              al_legal;
  logic              al_aligned;

  assign in_idle = (state_q == IDLE);
  assign in_req  = (state_q == REQ);

  assign al_we     = in_idle ? bus.req_we        : we_q;
  assign al_funct3 = in_idle ? bus.req_funct3    : funct3_q;
  assign al_off    = in_idle ? bus.req_addr[1:0] : addr_q[1:0];
  assign al_wdata  = in_idle ? bus.req_wdata     : wdata_q;

  lsu_lane_align u_align (
    .we_i      (al_we),
    .funct3_i  (al_funct3),
    .off_i     (al_off),
    .wdata_i   (al_wdata),
    .rdata_i   (bus.mem_rdata),
    .be_o      (al_be),
    .wdata_o   (al_wlanes),
    .rdata_o   (al_rdata),
    .legal_o   (al_legal),
    .aligned_o (al_aligned)
  );

  // Counter counts REQ+WAIT cycles together; it is not cleared on gnt.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      err_q      <= OK;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rd_q       <= 5'd0;
      rsp_data_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    rsp_data_d = rsp_data_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d       = bus.req_we;
          funct3_d   = bus.req_funct3;
          addr_d     = bus.req_addr;
          wdata_d    = bus.req_wdata;
          rd_d       = bus.req_rd;
          rsp_data_d = 32'h0;
          err_d      = OK;
          cnt_d      = '0;
          if (al_legal && al_aligned) begin
            state_d = REQ;
          end else begin
            state_d = RESP;
            err_d   = MISALIGN;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        // A grant in the expiry cycle still wins over the timeout.
        if (bus.mem_gnt) begin
          state_d = WAIT;
        end else if (timeout_hit) begin
          state_d = RESP;
          err_d   = TIMEOUT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.mem_rvalid) begin
          state_d = RESP;
          if (bus.mem_err) begin
            err_d      = BUSERR;
            rsp_data_d = 32'h0;
          end else begin
            err_d      = OK;
            rsp_data_d = we_q ? 32'h0 : al_rdata;
          end
        end else if (timeout_hit) begin
          state_d = RESP;
          err_d   = TIMEOUT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.req_ready = in_idle;
  assign bus.busy      = ~in_idle;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_rd    = rd_q;
  assign bus.rsp_err   = err_q;

  // Bus outputs are qualified by REQ so they read as zero whenever no
  // request is on the bus, including immediately on reset.
  assign bus.mem_req   = in_req;
  assign bus.mem_we    = in_req & we_q;
  assign bus.mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_be    = in_req ? al_be : 4'b0000;
  assign bus.mem_wdata = in_req ? al_wlanes : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_ctrl_if bus();

  lsu_ctrl #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_err    = 0;
  int n_checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic drive_cmd(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_rd     = rd;
  endtask

  // Full bus access: accept, optional grant delay (with a stray rvalid in REQ),
  // grant, one WAIT cycle, rvalid, then the response pulse.
  task automatic run_access(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [4:0] rd, input int gnt_delay,
                            input logic [31:0] rdata, input logic merr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_data, input logic [1:0] exp_err);
    @(negedge clk);
    chk1({tag, ".ready_idle"}, bus.req_ready, 1'b1);
    drive_cmd(we, f3, addr, wdata, rd);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk1({tag, ".busy_req"}, bus.busy, 1'b1);
    chk1({tag, ".ready_req"}, bus.req_ready, 1'b0);
    chk1({tag, ".mem_req"}, bus.mem_req, 1'b1);
    for (int i = 0; i < gnt_delay; i++) begin
      bus.mem_rvalid = (i == 0);
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      chk1({tag, ".mem_req_held"}, bus.mem_req, 1'b1);
      chk({tag, ".addr_held"}, bus.mem_addr, {addr[31:2], 2'b00});
      chk({tag, ".be_held"}, {28'd0, bus.mem_be}, {28'd0, exp_be});
    end
    chk1({tag, ".mem_we"}, bus.mem_we, we);
    chk({tag, ".mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
    chk({tag, ".mem_be"}, {28'd0, bus.mem_be}, {28'd0, exp_be});
    chk({tag, ".mem_wdata"}, bus.mem_wdata, exp_wdata);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    chk1({tag, ".mem_req_wait"}, bus.mem_req, 1'b0);
    chk1({tag, ".rsp_valid_wait"}, bus.rsp_valid, 1'b0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    bus.mem_err    = merr;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_err    = 1'b0;
    chk1({tag, ".rsp_valid"}, bus.rsp_valid, 1'b1);
    chk({tag, ".rsp_data"}, bus.rsp_data, exp_data);
    chk({tag, ".rsp_err"}, {30'd0, bus.rsp_err}, {30'd0, exp_err});
    chk({tag, ".rsp_rd"}, {27'd0, bus.rsp_rd}, {27'd0, rd});
    chk1({tag, ".busy_resp"}, bus.busy, 1'b1);
    $display("txn %s: we=%0d f3=%0d addr=0x%08h be=%b data=0x%08h err=%0d",
             tag, we, f3, addr, bus.mem_be, bus.rsp_data, bus.rsp_err);
    @(negedge clk);
    chk1({tag, ".rsp_pulse_end"}, bus.rsp_valid, 1'b0);
    chk1({tag, ".busy_end"}, bus.busy, 1'b0);
  endtask

  // Illegal or misaligned command: response the cycle after accept, no bus.
  task automatic run_err(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [4:0] rd);
    @(negedge clk);
    drive_cmd(we, f3, addr, 32'hFFFF_FFFF, rd);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk1({tag, ".rsp_valid"}, bus.rsp_valid, 1'b1);
    chk({tag, ".rsp_err"}, {30'd0, bus.rsp_err}, 32'd1);
    chk({tag, ".rsp_data"}, bus.rsp_data, 32'h0);
    chk({tag, ".rsp_rd"}, {27'd0, bus.rsp_rd}, {27'd0, rd});
    chk1({tag, ".no_mem_req"}, bus.mem_req, 1'b0);
    $display("txn %s: we=%0d f3=%0d addr=0x%08h err=%0d", tag, we, f3, addr, bus.rsp_err);
    @(negedge clk);
    chk1({tag, ".rsp_pulse_end"}, bus.rsp_valid, 1'b0);
    chk1({tag, ".ready_after"}, bus.req_ready, 1'b1);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_rd     = 5'd0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    bus.mem_err    = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    chk1("rst.req_ready", bus.req_ready, 1'b1);
    chk1("rst.busy", bus.busy, 1'b0);
    chk1("rst.rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst.rsp_data", bus.rsp_data, 32'h0);
    chk("rst.rsp_rd", {27'd0, bus.rsp_rd}, 32'd0);
    chk("rst.rsp_err", {30'd0, bus.rsp_err}, 32'd0);
    chk1("rst.mem_req", bus.mem_req, 1'b0);
    chk1("rst.mem_we", bus.mem_we, 1'b0);
    chk("rst.mem_be", {28'd0, bus.mem_be}, 32'd0);
    chk("rst.mem_addr", bus.mem_addr, 32'h0);
    chk("rst.mem_wdata", bus.mem_wdata, 32'h0);
    rst_n = 1'b1;

    // Loads and stores across widths/offsets
    run_access("lb_103",  1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd5,  0, 32'h8000_0000, 1'b0,
               4'b1000, 32'h0, 32'hFFFF_FF80, 2'd0);
    run_access("lbu_103", 1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd6,  0, 32'h8000_0000, 1'b0,
               4'b1000, 32'h0, 32'h0000_0080, 2'd0);
    run_access("sh_22",   1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD, 5'd7, 0, 32'h0, 1'b0,
               4'b1100, 32'hABCD_ABCD, 32'h0, 2'd0);
    run_access("lh_02",   1'b0, 3'b001, 32'h0000_0002, 32'h0, 5'd8,  0, 32'h8001_1234, 1'b0,
               4'b1100, 32'h0, 32'hFFFF_8001, 2'd0);
    run_access("lhu_00",  1'b0, 3'b101, 32'h0000_0000, 32'h0, 5'd9,  0, 32'h1234_F00D, 1'b0,
               4'b0011, 32'h0, 32'h0000_F00D, 2'd0);
    run_access("sb_41",   1'b1, 3'b000, 32'h0000_0041, 32'hFFFF_FF5A, 5'd10, 0, 32'h0, 1'b0,
               4'b0010, 32'h5A5A_5A5A, 32'h0, 2'd0);
    run_access("lb_01",   1'b0, 3'b000, 32'h0000_0001, 32'h0, 5'd11, 0, 32'h0000_7F00, 1'b0,
               4'b0010, 32'h0, 32'h0000_007F, 2'd0);
    // Error path after a nonzero load: rsp_data must come back as 0
    run_err("lw_06_misalign", 1'b0, 3'b010, 32'h0000_0006, 5'd12);
    run_err("ld_f3_011",      1'b0, 3'b011, 32'h0000_0000, 5'd13);
    run_err("st_f3_100",      1'b1, 3'b100, 32'h0000_0010, 5'd14);
    run_err("sh_23_misalign", 1'b1, 3'b001, 32'h0000_0023, 5'd15);
    run_err("lh_01_misalign", 1'b0, 3'b001, 32'h0000_0001, 5'd16);
    // Grant withheld 3 cycles (gnt lands on the timeout-expiry cycle), bus error
    run_access("lw_200_buserr", 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd17, 3, 32'hDEAD_BEEF, 1'b1,
               4'b1111, 32'h0, 32'h0, 2'd2);
    run_access("sw_300",  1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 5'd18, 0, 32'h0, 1'b0,
               4'b1111, 32'hCAFE_F00D, 32'h0, 2'd0);

    // Timeout: gnt never asserted
    @(negedge clk);
    drive_cmd(1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd19);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk1("to.mem_req_held", bus.mem_req, 1'b1);
      @(negedge clk);
    end
    chk1("to.mem_req_dropped", bus.mem_req, 1'b0);
    chk1("to.rsp_valid", bus.rsp_valid, 1'b1);
    chk("to.rsp_err", {30'd0, bus.rsp_err}, 32'd3);
    chk("to.rsp_data", bus.rsp_data, 32'h0);
    chk("to.rsp_rd", {27'd0, bus.rsp_rd}, 32'd19);
    $display("txn timeout: addr=0x00000040 err=%0d", bus.rsp_err);
    @(negedge clk);
    chk1("to.rsp_pulse_end", bus.rsp_valid, 1'b0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    chk1("stray.rsp_valid", bus.rsp_valid, 1'b0);
    chk1("stray.busy", bus.busy, 1'b0);
    chk1("stray.ready", bus.req_ready, 1'b1);
    $display("txn stray_rvalid: ignored busy=%0d", bus.busy);

    // Reset pulsed while in WAIT
    @(negedge clk);
    drive_cmd(1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd21);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.mem_gnt   = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    chk1("rw.busy_wait", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rw.mem_req", bus.mem_req, 1'b0);
    chk1("rw.busy", bus.busy, 1'b0);
    chk1("rw.ready", bus.req_ready, 1'b1);
    chk1("rw.rsp_valid", bus.rsp_valid, 1'b0);
    chk("rw.rsp_rd", {27'd0, bus.rsp_rd}, 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_5555;
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk1("rw.no_rsp", bus.rsp_valid, 1'b0);
    $display("txn reset_in_wait: abandoned rsp_valid=%0d", bus.rsp_valid);
    run_access("lw_after_rst", 1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd22, 0, 32'h0123_4567, 1'b0,
               4'b1111, 32'h0, 32'h0123_4567, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store sequencer between the CPU execute stage and the single-port data-memory bus.
- Accepts one load/store command and checks alignment and funct3 legality.
- Generates byte enables and lane-replicated write data.
- Runs the req/gnt/rvalid bus handshake, then byte-aligns and sign- or zero-extends read data.
- Returns one response per command; busy stalls the pipeline while an access is outstanding.

Parameters:
TIMEOUT_CYC, 255, cycles in REQ+WAIT before timeout abort; 0 disables the timeout
CNT_W, 8, timeout counter width; must satisfy TIMEOUT_CYC < 2**CNT_W

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  command valid
req_ready  out  1  command accepted when req_valid && req_ready
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32 load/store funct3
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
req_rd  in  5  destination register tag, echoed on response
rsp_valid  out  1  one-cycle response pulse, no backpressure
rsp_data  out  32  extended load data; 0 for stores and errors
rsp_rd  out  5  echoed tag
rsp_err  out  2  0=ok, 1=misaligned/illegal, 2=bus error, 3=timeout
busy  out  1  high from accept until the rsp_valid cycle inclusive
mem_req  out  1  bus request, held until mem_gnt
mem_we  out  1  bus write
mem_addr  out  32  word address {req_addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  bus accepts request this cycle
mem_rvalid  in  1  read data / write ack
mem_rdata  in  32  read word
mem_err  in  1  bus error, qualified by mem_rvalid

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, counter 0.
  - Outputs: req_ready=1, busy=0, rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_err=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - Reset asserted mid-access drops mem_req immediately; the access is abandoned with no response.
- Command capture: on accept, funct3, we, addr, wdata and rd are registered and stay stable until RESP.
- FSM states: IDLE, REQ, WAIT, RESP.
  - IDLE: req_ready=1. On accept of a legal aligned command go to REQ; on an illegal or misaligned command go to RESP with err=1 and no bus activity.
  - REQ: mem_req=1 with mem_we/addr/be/wdata stable. On mem_gnt go to WAIT. mem_rvalid in REQ is ignored.
  - WAIT: mem_req=0. On mem_rvalid go to RESP and capture data and mem_err (err=2 if set).
  - RESP: rsp_valid=1 for exactly one cycle, then go to IDLE. req_ready=0 in REQ, WAIT and RESP.
- Latency (aligned access, gnt in the first REQ cycle, rvalid one cycle after gnt):
  - Accept at T; mem_req at T+1; rvalid at T+2; rsp_valid at T+3.
  - Error path: accept at T, rsp_valid at T+1.
- Legality:
  - Loads: funct3 000, 001, 010, 100, 101 are legal.
  - Stores: funct3 000, 001, 010 are legal.
  - Everything else: err=1.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0, gives err=1.
- Store lanes (off=addr[1:0]):
  - SB: be=4'b0001<<off, wdata={4{b}}.
  - SH: be=4'b0011<<off, wdata={2{h}}.
  - SW: be=4'b1111.
- Load mem_be: same mask as the store case for each width (LB/LBU byte, LH/LHU halfword, LW word).
- Load data: shift mem_rdata right by 8*off, then extend.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - The result is registered into rsp_data.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When count==TIMEOUT_CYC−1 and no gnt (in REQ) or no rvalid (in WAIT), go to RESP with err=3 and drop mem_req.
  - A later stray mem_rvalid in IDLE is ignored.
  - If gnt or rvalid arrives in the same cycle as expiry, the bus event wins.
- Stores: rsp_valid is raised on ack with rsp_data=0 and err per mem_err.

Decomposition:
- lsu_pkg:
  - funct3 constants (F3_LB…F3_LHU, F3_SB/SH/SW).
  - lsu_state_e {IDLE, REQ, WAIT, RESP}.
  - lsu_err_e {OK, MISALIGN, BUSERR, TIMEOUT}.
- Sub-module lsu_lane_align (combinational):
  - Inputs funct3, off, wdata, rdata.
  - Outputs be, store lanes, extended load data, legal/aligned flags.
- lsu_ctrl owns the FSM, capture registers and timeout counter.

Test Plan:
- Load LB, addr 0x103, mem_rdata 0x80_00_00_00, gnt at T+1, rvalid at T+2 -> mem_be=4'b1000, mem_addr=0x100, rsp_valid at T+3, rsp_data=0xFFFF_FF80, err=0; same access as LBU -> rsp_data=0x0000_0080.
- Store SH, addr 0x22, wdata 0x1234_ABCD -> mem_we=1, mem_be=4'b1100, mem_wdata=0xABCD_ABCD; ack -> rsp_valid, err=0, rsp_data=0.
- LW at addr 0x06 -> no mem_req; rsp_valid at T+1, err=1; funct3=011 load -> err=1.
- mem_gnt withheld 3 cycles -> mem_req held with stable addr/be, req_ready=0; rvalid with mem_err=1 -> err=2.
- TIMEOUT_CYC=4, gnt never asserted -> mem_req deasserts after 4 cycles, rsp err=3, stray rvalid afterwards ignored.
- rst_n pulsed low while in WAIT -> outputs immediately at reset values, no rsp_valid; the next command completes normally.
